// File: rtl/key_expand.sv
// AES-128 key schedule: streams a 128-bit key in as four words,
// expands to 44 words one per cycle, and serves any round-key word.
module key_expand (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cipher_key,
  input  logic [1:0]  r_index,
  input  logic [3:0]  round_key_num,
  output logic [31:0] round_key,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    unique case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] w [44];
  logic        load_we;
  logic        exp_we;
  logic [31:0] prev;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [5:0]  rd_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // start from any state restarts the load at w[0]
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      unique case (state)
        LOAD:
          if (cnt == 6'd3) state_nxt = EXPAND;
        EXPAND:
          if (cnt == 6'd43) state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    load_we = (state == LOAD) && !start;
    exp_we  = (state == EXPAND) && !start;
  end

  always_comb begin
    prev = w[cnt - 6'd1];
    rot  = {prev[23:0], prev[31:24]};
    sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]],
            SBOX[rot[15:8]],  SBOX[rot[7:0]]};
    if (cnt[1:0] == 2'b00)
      temp = sub ^ {rcon(cnt[5:2]), 24'h0};
    else
      temp = prev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      done <= 1'b0;
      for (int k = 0; k < 44; k++) w[k] <= '0;
    end else if (start) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      if (load_we) begin
        w[cnt] <= cipher_key;
        cnt    <= cnt + 6'd1;
      end
      if (exp_we) begin
        w[cnt] <= w[cnt - 6'd4] ^ temp;
        cnt    <= cnt + 6'd1;
        if (cnt == 6'd43) done <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_idx = {round_key_num, 2'b00} + {4'b0000, r_index};
    if (round_key_num > 4'd10)
      round_key = '0;
    else
      round_key = w[rd_idx];
  end

endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: known-answer table, timing of done,
// abort/reset corners and random keys against a GF(2^8) model.
module tb_key_expand;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cipher_key;
  logic [1:0]  r_index;
  logic [3:0]  round_key_num;
  logic [31:0] round_key;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [44];
  logic [127:0] cur_key;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rn;
    logic [1:0]   ri;
    logic [31:0]  exp;
  } vec_t;

  vec_t vecs [14];

  key_expand dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cipher_key    (cipher_key),
    .r_index       (r_index),
    .round_key_num (round_key_num),
    .round_key     (round_key),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: field inverse then affine map
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 0;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
            ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) mw[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = mw[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      mw[i] = mw[i-4] ^ t;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // start pulse, four key words, garbage afterwards; done checked per edge
  task automatic load_key(input logic [127:0] key);
    @(negedge clk);
    start = 1'b1;
    cipher_key = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_clr_at_start", {31'b0, done}, 32'd0);
    for (int e = 1; e <= 44; e++) begin
      cipher_key = (e <= 4) ? key[127 - 32*(e-1) -: 32] : $urandom;
      @(posedge clk);
      @(negedge clk);
      if (e < 44) chk($sformatf("done_low_e%0d", e), {31'b0, done}, 32'd0);
      else        chk("done_high_e44", {31'b0, done}, 32'd1);
    end
    cur_key = key;
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r <= 10; r++)
      for (int j = 0; j < 4; j++) begin
        round_key_num = 4'(r);
        r_index = 2'(j);
        #1;
        chk($sformatf("%s_r%0d_w%0d", tag, r, j), round_key, mw[4*r+j]);
      end
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r <= 15; r++)
      for (int j = 0; j < 4; j++) begin
        round_key_num = 4'(r);
        r_index = 2'(j);
        #1;
        chk($sformatf("%s_r%0d_w%0d", tag, r, j), round_key, 32'h0);
      end
  endtask

  task automatic feed_words(input logic [127:0] key, input int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < n; e++) begin
      cipher_key = (e < 4) ? key[127 - 32*e -: 32] : $urandom;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h5468617473206d79204b756e67204675;

  initial begin
    logic [127:0] rk;
    vecs[0]  = '{K1, 4'd0,  2'd0, 32'h2b7e1516};
    vecs[1]  = '{K1, 4'd0,  2'd1, 32'h28aed2a6};
    vecs[2]  = '{K1, 4'd0,  2'd2, 32'habf71588};
    vecs[3]  = '{K1, 4'd0,  2'd3, 32'h09cf4f3c};
    vecs[4]  = '{K1, 4'd1,  2'd0, 32'ha0fafe17};
    vecs[5]  = '{K1, 4'd10, 2'd0, 32'hd014f9a8};
    vecs[6]  = '{K1, 4'd10, 2'd1, 32'hc9ee2589};
    vecs[7]  = '{K1, 4'd10, 2'd2, 32'he13f0cc8};
    vecs[8]  = '{K1, 4'd10, 2'd3, 32'hb6630ca6};
    vecs[9]  = '{K2, 4'd1,  2'd0, 32'he232fcf1};
    vecs[10] = '{K2, 4'd1,  2'd3, 32'hd679a293};
    vecs[11] = '{K2, 4'd10, 2'd0, 32'h28fddef8};
    vecs[12] = '{K2, 4'd10, 2'd1, 32'h6da4244a};
    vecs[13] = '{K2, 4'd10, 2'd3, 32'h3b316f26};

    reset = 1'b1;
    start = 1'b0;
    cipher_key = '0;
    r_index = '0;
    round_key_num = '0;
    cur_key = '0;
    build_sbox();
    chk("sbox_00", {24'h0, sb[0]}, 32'h63);
    chk("sbox_53", {24'h0, sb[8'h53]}, 32'hed);

    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_done", {31'b0, done}, 32'd0);
    check_zero("reset");

    // known-answer table
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].key !== cur_key) load_key(vecs[v].key);
      round_key_num = vecs[v].rn;
      r_index = vecs[v].ri;
      #1;
      chk($sformatf("kat%0d", v), round_key, vecs[v].exp);
    end

    // done holds after completion
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("done_hold%0d", c), {31'b0, done}, 32'd1);
    end

    model(K2);
    check_all("k2");
    for (int r = 11; r <= 15; r++)
      for (int j = 0; j < 4; j++) begin
        round_key_num = 4'(r);
        r_index = 2'(j);
        #1;
        chk($sformatf("oob_r%0d_w%0d", r, j), round_key, 32'h0);
      end

    // new start while in DONE
    load_key(K1);
    model(K1);
    check_all("restart_done");

    // reset mid-EXPAND, then a fresh key
    rk = {$urandom, $urandom, $urandom, $urandom};
    feed_words(rk, 20);
    do_reset();
    chk("rst_exp_done", {31'b0, done}, 32'd0);
    check_zero("rst_exp");
    load_key(K2);
    model(K2);
    check_all("after_rst");

    // abort mid-LOAD and mid-EXPAND
    feed_words(K1, 2);
    rk = {$urandom, $urandom, $urandom, $urandom};
    load_key(rk);
    model(rk);
    check_all("abort_load");
    feed_words(K2, 12);
    load_key(K1);
    model(K1);
    check_all("abort_exp");

    // reset and start on the same edge: reset wins
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    cipher_key = 32'hdeadbeef;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("rst_start_done", {31'b0, done}, 32'd0);
    round_key_num = 4'd0;
    r_index = 2'd0;
    #1;
    chk("rst_start_w0", round_key, 32'h0);
    round_key_num = 4'd1;
    #1;
    chk("rst_start_w4", round_key, 32'h0);

    // random keys
    for (int t = 0; t < 5; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      load_key(rk);
      model(rk);
      check_all($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
